// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
// Scan controller for a shared hex segment decoder. Each digit slot is an
// all-off guard interval followed by a drive interval. New display data is
// held in a pending buffer and becomes active only at a frame boundary, or
// at once while the display is off.
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL_CYC  = 50000,
   parameter int GUARD_CYC  = 500
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    scan_en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic                    load_ack,
   output logic [3:0]              dec_inp,
   output logic [NUM_DIGITS-1:0]   digit_en
);

   localparam int MAXC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_GUARD = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   state_t                  state, nstate;
   logic [CW-1:0]           cnt, ncnt;
   logic [IW-1:0]           idx, nidx;
   logic                    frame_end;

   logic [4*NUM_DIGITS-1:0] act_data, pend_data, nxt_data;
   logic [NUM_DIGITS-1:0]   act_blank, pend_blank, nxt_blank;
   logic                    pend_valid;
   logic                    apply;

   logic [3:0]              dec_nxt;
   logic [NUM_DIGITS-1:0]   en_nxt;

   // State, slot counter and digit index registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= S_OFF;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         idx   <= nidx;
      end
   end

   // Next-state logic: guard then drive for every digit, frame end after the
   // last digit's drive; scan_en low forces OFF from any state
   always_comb begin
      nstate    = state;
      ncnt      = cnt;
      nidx      = idx;
      frame_end = 1'b0;
      if (!scan_en) begin
         nstate = S_OFF;
         ncnt   = '0;
         nidx   = '0;
      end else begin
         case (state)
            S_OFF: begin
               nstate = S_GUARD;
               ncnt   = '0;
               nidx   = '0;
            end
            S_GUARD: begin
               if (cnt == GUARD_LAST) begin
                  nstate = S_DRIVE;
                  ncnt   = '0;
               end else begin
                  ncnt = cnt + 1'b1;
               end
            end
            S_DRIVE: begin
               if (cnt == DWELL_LAST) begin
                  nstate = S_GUARD;
                  ncnt   = '0;
                  if (idx == IDX_LAST) begin
                     nidx      = '0;
                     frame_end = 1'b1;
                  end else begin
                     nidx = idx + 1'b1;
                  end
               end else begin
                  ncnt = cnt + 1'b1;
               end
            end
            default: begin
               nstate = S_OFF;
               ncnt   = '0;
               nidx   = '0;
            end
         endcase
      end
   end

   // Pending data goes live at the last cycle of a frame, or whenever the
   // display is dark (OFF now, or about to be)
   always_comb begin
      apply     = pend_valid & (frame_end | (state == S_OFF) | ~scan_en);
      nxt_data  = apply ? pend_data  : act_data;
      nxt_blank = apply ? pend_blank : act_blank;
   end

   // Double buffer: a load always lands in pending (latest wins); an apply
   // in the same cycle as a load uses the older pending contents
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pend_data  <= '0;
         pend_blank <= '1;
         pend_valid <= 1'b0;
         act_data   <= '0;
         act_blank  <= '1;
      end else begin
         act_data  <= nxt_data;
         act_blank <= nxt_blank;
         if (load) begin
            pend_data  <= data_in;
            pend_blank <= blank_in;
            pend_valid <= 1'b1;
         end else if (apply) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // Output values for the upcoming cycle, derived from the next state so the
   // registered outputs line up with the state they describe; the decoder
   // input is already valid during guard so segments settle before enable
   always_comb begin
      dec_nxt = 4'h0;
      en_nxt  = '1;
      if (nstate != S_OFF) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (nidx == IW'(i)) begin
               dec_nxt   = nxt_data[4*i +: 4];
               en_nxt[i] = ~((nstate == S_DRIVE) & ~nxt_blank[i]);
            end
         end
      end
   end

   // Registered outputs
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         dec_inp  <= 4'h0;
         digit_en <= '1;
         load_ack <= 1'b0;
      end else begin
         dec_inp  <= dec_nxt;
         digit_en <= en_nxt;
         load_ack <= apply;
      end
   end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the shared 4-to-7 hex segment decoder. It holds NUM_DIGITS hex nibbles and presents one nibble at a time on the decoder input, while driving the matching active-low digit-enable line. A non-enabled guard interval between digits suppresses ghosting. New display data is double-buffered and applied only at a frame boundary, so a frame never shows mixed old and new digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_CYC, 50000, clock cycles each digit is driven per frame (>=1)
GUARD_CYC, 500, clock cycles all digits are off before each digit slot (>=1)

Ports:
Clk  input  1  system clock, rising-edge
Rst  input  1  asynchronous, active-low reset
scan_en  input  1  1 = scanning; 0 = display dark, scan held at digit 0
load  input  1  single-cycle strobe: capture data_in and blank_in as pending
data_in  input  4*NUM_DIGITS  nibble i = data_in[4i+3:4i], shown on digit i
blank_in  input  NUM_DIGITS  bit i = 1 keeps digit i dark during its slot
load_ack  output  1  one-cycle pulse when pending data becomes active
dec_inp  output  4  nibble to the shared segment decoder
digit_en  output  NUM_DIGITS  active-low digit select; at most one bit low at any time

Behaviour:
- Interface: one clock (Clk); reset Rst is asynchronous, active-low. All outputs are registered.
- Reset values: state=OFF, idx=0, cycle counter=0, active data=0, active blank=all 1, pending_valid=0, dec_inp=4'h0, digit_en=all 1, load_ack=0.
- States: OFF, GUARD, DRIVE.
- OFF: digit_en all 1, dec_inp=0, idx=0. If scan_en=1, go to GUARD next cycle.
- GUARD: digit_en all 1. dec_inp = active nibble[idx], which pre-settles the decoder. Lasts exactly GUARD_CYC cycles, then goes to DRIVE.
- DRIVE: digit_en[idx]=0 unless active blank[idx]=1. dec_inp = active nibble[idx]. Lasts exactly DWELL_CYC cycles.
- At the end of DRIVE: if idx = NUM_DIGITS-1, this is a frame boundary and idx wraps to 0; otherwise idx increments. The next state is GUARD.
- Frame length = NUM_DIGITS*(GUARD_CYC+DWELL_CYC) cycles.
- scan_en=0 in any state: go to OFF on the next edge. digit_en goes all 1 the same cycle the registered output updates. Counter and idx clear.
- Load capture: load=1 copies data_in and blank_in into the pending registers and sets pending_valid.
- A second load before the data is applied overwrites pending (latest wins). No ack is issued for the overwritten data.
- Apply, scanning case: on the frame-boundary cycle, if pending_valid=1, active <= pending, pending_valid <= 0, and load_ack=1 in the following cycle. The first GUARD of the new frame shows the new data.
- Apply, OFF case: when the state is OFF (or scan_en=0) and pending_valid=1, apply on the next edge and pulse load_ack.
- load coincident with a frame boundary: the boundary applies the previously pending data (if any). The new load is captured into pending and applied at the next boundary. If nothing was previously pending, no ack is issued at this boundary.
- Counter width is ceil(log2(max(DWELL_CYC,GUARD_CYC)+1)). idx width is ceil(log2(NUM_DIGITS)). No overflow is permitted.
- Reset asserted mid-frame: immediate return to reset values. Pending data is discarded.

Test Plan:
- Use NUM_DIGITS=4, DWELL_CYC=5, GUARD_CYC=2 throughout.
- Reset, then scan_en=1 with active data 0 → digit_en stays 4'b1111 for all 28 cycles (all blank after reset); load_ack=0.
- With scan_en=0, load data_in=16'h3A71, blank_in=0 → load_ack pulses 1 cycle later.
  - Then set scan_en=1 → sequence: 2 cycles of 1111; 5 cycles of 1110 with dec_inp=1; 2 off; 5 cycles of 1101 with dec_inp=7; then A on digit 2, then 3 on digit 3; repeats every 28 cycles.
- Mid-frame load 16'hFFFF while scanning 16'h3A71 → remaining slots in the current frame still show 7, A, 3.
  - load_ack occurs 1 cycle after the boundary; the next frame shows F on all digits.
- Two loads in one frame (16'h1111, then 16'h2222) → a single load_ack; the next frame shows 2 on all digits.
- blank_in=4'b0100 → digit_en[2] never goes low; slot timing is unchanged (still 28 cycles per frame).
- Rst low during DRIVE of digit 2 with pending data → all outputs return to reset values immediately; no load_ack after release.
  - Then drop scan_en mid-DRIVE → digit_en=1111 by the next cycle; idx restarts at 0.
